// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined adder: slice sizing and internal flag positions.
// Pure declarations; no logic, no latency.
// Not applicable (no handshake).
package adder_pkg;

  // Bit positions of the flags when they are gathered into one vector
  localparam int FLAG_CARRY = 0;
  localparam int FLAG_OVF   = 1;
  localparam int FLAG_ZERO  = 2;
  localparam int FLAG_W     = 3;

  // Width of one carry-chained slice; DATA_WIDTH must be a multiple of STAGES
  function automatic int slice_width(input int data_width, input int stages);
    return data_width / stages;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// One SW-bit slice of the carry chain: sum, carry-out, slice-is-zero and result MSB.
// Purely combinational, zero latency.
// No handshake; the enclosing stage register decides when results are captured.
module adder_slice #(
  parameter int SW = 8
) (
  input  logic [SW-1:0] a_i,
  input  logic [SW-1:0] b_i,
  input  logic          cin_i,
  output logic [SW-1:0] sum_o,
  output logic          cout_o,
  output logic          zero_o,
  output logic          msb_o
);

  logic [SW:0] full;

  assign full   = {1'b0, a_i} + {1'b0, b_i} + {{SW{1'b0}}, cin_i};
  assign sum_o  = full[SW-1:0];
  assign cout_o = full[SW];
  assign zero_o = (full[SW-1:0] == '0);
  assign msb_o  = full[SW-1];

endmodule

// File: rtl/pipe_adder.sv
// Pipelined add/subtract: STAGES carry-chained slices, one slice resolved per stage.
// Latency STAGES cycles from the accepting edge; one bundle per cycle when unstalled.
// Global stall: whole pipe holds while the output is valid and not taken (ready_out = !valid_out | ready_in).
// Optional flags (carry/overflow/zero) are built only when PIPE_ADDER_FLAGS_EN is defined.
module pipe_adder
  import adder_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int STAGES     = 4
) (
  input  logic                  clock_in,
  input  logic                  reset_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  input  logic [DATA_WIDTH-1:0] a_operand_in,
  input  logic [DATA_WIDTH-1:0] b_operand_in,
  input  logic                  sub_in,
  input  logic                  carry_in,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic [DATA_WIDTH-1:0] add_result_out,
  output logic                  carry_out,
  output logic                  overflow_out,
  output logic                  zero_out
);

  localparam int SW   = slice_width(DATA_WIDTH, STAGES);
  localparam int LAST = STAGES - 1;
  localparam int MSB  = DATA_WIDTH - 1;

  logic                  en;
  logic [DATA_WIDTH-1:0] b_eff;

  // Stage registers; operand copies carry the not-yet-consumed upper slices forward
  logic [STAGES-1:0]     vld_q, cy_q;
  logic [DATA_WIDTH-1:0] a_q   [STAGES];
  logic [DATA_WIDTH-1:0] b_q   [STAGES];
  logic [DATA_WIDTH-1:0] res_q [STAGES];

  // Next-state of each stage, built from the previous stage (or the inputs)
  logic [STAGES-1:0]     vld_d, cy_d, cin_w, zero_w, msb_w;
  logic [DATA_WIDTH-1:0] a_d      [STAGES];
  logic [DATA_WIDTH-1:0] b_d      [STAGES];
  logic [DATA_WIDTH-1:0] res_in_w [STAGES];
  logic [DATA_WIDTH-1:0] res_d    [STAGES];
  logic [SW-1:0]         sum_w    [STAGES];

  assign b_eff     = b_operand_in ^ {DATA_WIDTH{sub_in}};
  assign en        = !vld_q[LAST] || ready_in;
  assign ready_out = en;

`ifdef PIPE_ADDER_FLAGS_EN
  logic [STAGES-1:0] zacc_d, zacc_q;
  logic              ovf_d, ovf_q;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign vld_d[k]    = valid_in;
      assign a_d[k]      = a_operand_in;
      assign b_d[k]      = b_eff;
      assign cin_w[k]    = sub_in | carry_in;
      assign res_in_w[k] = '0;
`ifdef PIPE_ADDER_FLAGS_EN
      assign zacc_d[k]   = zero_w[k];
`endif
    end else begin : g_tail
      assign vld_d[k]    = vld_q[k-1];
      assign a_d[k]      = a_q[k-1];
      assign b_d[k]      = b_q[k-1];
      assign cin_w[k]    = cy_q[k-1];
      assign res_in_w[k] = res_q[k-1];
`ifdef PIPE_ADDER_FLAGS_EN
      assign zacc_d[k]   = zero_w[k] & zacc_q[k-1];
`endif
    end

    adder_slice #(.SW(SW)) u_slice (
      .a_i    (a_d[k][k*SW +: SW]),
      .b_i    (b_d[k][k*SW +: SW]),
      .cin_i  (cin_w[k]),
      .sum_o  (sum_w[k]),
      .cout_o (cy_d[k]),
      .zero_o (zero_w[k]),
      .msb_o  (msb_w[k])
    );

    // Slices above k are still zero in res_in, so OR-ing the new slice in is enough
    assign res_d[k] = res_in_w[k] | (DATA_WIDTH'(sum_w[k]) << (k*SW));
  end

  // All stages shift together when enabled, hold otherwise; reset flushes everything
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      vld_q <= '0;
      cy_q  <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        res_q[k] <= '0;
      end
    end else if (en) begin
      vld_q <= vld_d;
      cy_q  <= cy_d;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        res_q[k] <= res_d[k];
      end
    end
  end

  assign valid_out      = vld_q[LAST];
  assign add_result_out = res_q[LAST];

`ifdef PIPE_ADDER_FLAGS_EN
  logic [FLAG_W-1:0] flags;
  logic              unused_bits;

  // Operand MSBs live in the top slice, so overflow is resolved in the last stage only
  assign ovf_d = (a_d[LAST][MSB] == b_d[LAST][MSB]) && (msb_w[LAST] != a_d[LAST][MSB]);

  // Flag registers follow the same enable/reset as the data path
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      zacc_q <= '0;
      ovf_q  <= 1'b0;
    end else if (en) begin
      zacc_q <= zacc_d;
      ovf_q  <= ovf_d;
    end
  end

  assign flags[FLAG_CARRY] = cy_q[LAST];
  assign flags[FLAG_OVF]   = ovf_q;
  assign flags[FLAG_ZERO]  = zacc_q[LAST];
  assign carry_out         = flags[FLAG_CARRY];
  assign overflow_out      = flags[FLAG_OVF];
  assign zero_out          = flags[FLAG_ZERO];

  // Last-stage operand copies and lower-slice MSBs have no consumer
  assign unused_bits = ^{a_q[LAST], b_q[LAST], msb_w};
`else
  logic unused_bits;

  assign carry_out    = 1'b0;
  assign overflow_out = 1'b0;
  assign zero_out     = 1'b0;

  // Flag-only signals are left dangling and trimmed away
  assign unused_bits = ^{a_q[LAST], b_q[LAST], msb_w, zero_w, cy_q[LAST]};
`endif

endmodule

// File: tb/tb_pipe_adder.sv
module tb_pipe_adder;

`ifdef PIPE_ADDER_FLAGS_EN
  localparam logic FL = 1'b1;
`else
  localparam logic FL = 1'b0;
`endif

  logic        clock_in = 1'b0;
  logic        reset_in, valid_in, ready_out, sub_in, carry_in;
  logic        valid_out, ready_in, carry_out, overflow_out, zero_out;
  logic [31:0] a_operand_in, b_operand_in, add_result_out;

  int tests_run = 0;
  int tests_failed = 0;

  pipe_adder #(.DATA_WIDTH(32), .STAGES(4)) dut (
    .clock_in       (clock_in),
    .reset_in       (reset_in),
    .valid_in       (valid_in),
    .ready_out      (ready_out),
    .a_operand_in   (a_operand_in),
    .b_operand_in   (b_operand_in),
    .sub_in         (sub_in),
    .carry_in       (carry_in),
    .valid_out      (valid_out),
    .ready_in       (ready_in),
    .add_result_out (add_result_out),
    .carry_out      (carry_out),
    .overflow_out   (overflow_out),
    .zero_out       (zero_out)
  );

  always #5 clock_in = !clock_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Single bundle into an empty pipe; latency counts edges including the accepting one
  task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic cin, input logic [31:0] er,
                         input logic ec, input logic ev, input logic ez);
    int lat;
    valid_in = 1'b1; a_operand_in = a; b_operand_in = b; sub_in = sub; carry_in = cin;
    @(posedge clock_in); #1;
    valid_in = 1'b0;
    lat = 1;
    while (!valid_out && lat < 20) begin
      @(posedge clock_in); #1;
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'd4);
    chk({tag, "_res"}, add_result_out, er);
    chk({tag, "_cy"},  32'(carry_out),    32'(ec & FL));
    chk({tag, "_ovf"}, 32'(overflow_out), 32'(ev & FL));
    chk({tag, "_z"},   32'(zero_out),     32'(ez & FL));
    @(posedge clock_in); #1;
  endtask

  logic [31:0] exp_q [8];
  logic [31:0] sa, sb;
  logic        acc;
  int sent, rcv, ocyc;

  initial begin
    reset_in = 1'b1; valid_in = 1'b0; ready_in = 1'b1; sub_in = 1'b0; carry_in = 1'b0;
    a_operand_in = '0; b_operand_in = '0;
    repeat (2) @(posedge clock_in);
    #1 reset_in = 1'b0;

    // Reset state
    chk("rst_vld",  32'(valid_out), 32'd0);
    chk("rst_rdy",  32'(ready_out), 32'd1);
    chk("rst_res",  add_result_out, 32'd0);
    chk("rst_cy",   32'(carry_out), 32'd0);
    chk("rst_ovf",  32'(overflow_out), 32'd0);
    chk("rst_z",    32'(zero_out), 32'd0);

    // Directed vectors: a, b, sub, cin -> result, carry, overflow, zero
    run_one("wrap",    32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    run_one("sub57",   32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    run_one("posovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    run_one("negovf",  32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    run_one("cin",     32'h0000_0010, 32'h0000_0020, 1'b0, 1'b1, 32'h0000_0031, 1'b0, 1'b0, 1'b0);
    run_one("subcin",  32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    run_one("subeq",   32'h0001_0000, 32'h0001_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    run_one("lowzero", 32'h0000_0100, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
    run_one("minmin",  32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1);

    // Stream of 8 with the consumer stalling on output cycles 2..4
    sent = 0; rcv = 0; ocyc = 0;
    for (int cyc = 0; cyc < 100 && rcv < 8; cyc++) begin
      sa = 32'h1234_5678 * 32'(sent + 1);
      sb = 32'h0F0F_F0F0 + 32'(sent);
      valid_in = (sent < 8); a_operand_in = sa; b_operand_in = sb;
      sub_in = sent[0]; carry_in = 1'b0;
      if (sent < 8) exp_q[sent] = sent[0] ? sa - sb : sa + sb;
      ready_in = !(valid_out && ocyc >= 1 && ocyc <= 3);
      @(negedge clock_in);
      chk("str_rdy", 32'(ready_out), 32'(!(valid_out && !ready_in)));
      if (valid_out) begin
        ocyc++;
        chk("str_res", add_result_out, exp_q[rcv]);
        if (ready_in) rcv++;
      end
      acc = valid_in && ready_out;
      @(posedge clock_in); #1;
      if (acc) sent++;
    end
    valid_in = 1'b0; ready_in = 1'b1;
    chk("str_cnt", 32'(rcv), 32'd8);
    chk("str_stalls", 32'(ocyc), 32'd11);
    repeat (6) begin
      @(negedge clock_in);
      chk("str_nodup", 32'(valid_out), 32'd0);
    end

    // Reset while three bundles are in flight
    @(posedge clock_in); #1;
    for (int i = 0; i < 3; i++) begin
      valid_in = 1'b1; a_operand_in = 32'(i + 1); b_operand_in = 32'd100; sub_in = 1'b0;
      @(posedge clock_in); #1;
    end
    valid_in = 1'b0; reset_in = 1'b1;
    @(posedge clock_in); #1;
    reset_in = 1'b0;
    chk("flush_res", add_result_out, 32'd0);
    chk("flush_rdy", 32'(ready_out), 32'd1);
    repeat (6) begin
      @(negedge clock_in);
      chk("flush_vld", 32'(valid_out), 32'd0);
    end
    @(posedge clock_in); #1;
    run_one("post_rst", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
